byte_frame_collector: RTL
=========================

Name: byte_frame_collector

Overview:
Upstream feeder for the 16-lane accumulate-and-register summing stage. It collects a serial stream of 8-bit samples over a valid/ready handshake into a 16-lane parallel frame. It presents the complete frame with a frame-valid flag and holds it stable until the consumer acknowledges it. Lane 0 maps to the summer's first operand (a), lane 15 to the last (p).

Parameters:
DATA_WIDTH, 8, width of each sample/lane in bits
LANES, 16, number of samples per frame (must be >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_WIDTH  incoming sample
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  collector can accept a sample this cycle
clear  input  1  synchronous abort of the partial or held frame
frame_out  output  LANES*DATA_WIDTH  flattened frame, lane n at bits [n*DATA_WIDTH +: DATA_WIDTH]
frame_valid  output  1  frame_out holds a complete frame
frame_ack  input  1  consumer has taken the frame
fill_count  output  clog2(LANES)+1  number of lanes filled in the current frame

Behaviour:
- Reset (async, rst=1):
  - state=FILL, fill_count=0, frame_valid=0, all lanes=0, so frame_out=0.
  - in_ready reads 1 while in FILL, including the reset state.
  - Sources must not drive in_valid while rst=1. Any such handshake is ignored.
- States: FILL, HOLD.
- in_ready = (state==FILL). It is combinational from state only and never depends on in_valid.
- Transfer: in_valid && in_ready on a rising edge.
- FILL:
  - Each transfer writes in_data into lane[fill_count] and increments fill_count.
  - A transfer when fill_count==LANES-1 writes the last lane, sets fill_count=LANES, and moves to HOLD.
  - frame_valid=1 from the next cycle. Latency from the last accepted byte to frame_valid is 1 cycle.
  - frame_ack in FILL is ignored.
- HOLD:
  - in_ready=0, frame_valid=1, and frame_out is stable every cycle.
  - frame_ack=1 moves to FILL with fill_count=0 and frame_valid=0 on the next edge.
  - The first new byte can be accepted the cycle after the ack.
  - Minimum frame period is LANES+1 cycles.
- Lane contents are not cleared on ack or clear. Stale lanes are overwritten by the next frame. frame_out is meaningful only while frame_valid=1.
- clear (synchronous, highest priority after rst):
  - Forces FILL, fill_count=0, frame_valid=0 on the next edge.
  - A transfer in the same cycle as clear is discarded: the lane is not written and the count is not advanced.
  - clear in HOLD drops the held frame even if frame_ack is also high.
- No arithmetic beyond the counter. fill_count never exceeds LANES and never wraps.
- Reset mid-frame: all state returns to reset values immediately (async). The partial frame is lost.

Test Plan:
- Reset, then stream bytes 0x01..0x10 with in_valid held high -> in_ready=1 for 16 cycles. frame_valid rises 1 cycle after the 16th byte. Lane0=0x01, lane15=0x10. Downstream sum = 0x88 (136).
- Hold a frame with frame_ack=0 for 10 cycles while in_valid=1 with data 0xFF -> in_ready=0, frame_out unchanged, fill_count=16. Assert frame_ack -> next cycle frame_valid=0, fill_count=0, in_ready=1.
- Throttled source: in_valid toggles every other cycle with 0xFF bytes -> frame completes after 16 accepted bytes (~32 cycles). All lanes=0xFF. Downstream sum = 0xFF0 (4080).
- After 7 bytes, assert clear with in_valid=1 and data 0xAA -> fill_count=0, lane7 not written as 0xAA. The next 16 bytes form a clean frame with no leftover data.
- Assert rst asynchronously (mid-cycle) after 5 bytes -> frame_valid=0, fill_count=0, and frame_out=0 immediately without waiting for a clock edge.
- Back-to-back frames with frame_ack pulsed on the first HOLD cycle -> the frame period measures exactly 17 cycles and the second frame's lanes match the second stream.

Source files
------------

// File: rtl/byte_frame_collector_if.sv
// byte_frame_collector_if: serial sample stream in, parallel frame out with ack.
interface byte_frame_collector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16
);
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        clear;
    logic [LANES*DATA_WIDTH-1:0] frame_out;
    logic                        frame_valid;
    logic                        frame_ack;
    logic [$clog2(LANES):0]      fill_count;

    modport master (
        output in_data, in_valid, clear, frame_ack,
        input  in_ready, frame_out, frame_valid, fill_count
    );

    modport slave (
        input  in_data, in_valid, clear, frame_ack,
        output in_ready, frame_out, frame_valid, fill_count
    );
endinterface

// File: rtl/byte_frame_collector.sv
// byte_frame_collector: gathers LANES serial samples into one held parallel frame.
module byte_frame_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16
) (
    input logic                  clk,
    input logic                  rst,
    byte_frame_collector_if.slave bus
);
    localparam int CW = $clog2(LANES) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic          xfer, last;

    // clear discards any transfer presented in the same cycle
    assign xfer = bus.in_valid && state == FILL && !bus.clear;
    assign last = count == CW'(LANES - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FILL;
        else     state <= state_nx;

    always_comb
        state_nx = bus.clear ? FILL :
                   state == FILL ? ((xfer && last) ? HOLD : FILL) :
                   (bus.frame_ack ? FILL : HOLD);

    always_comb begin
        bus.in_ready    = state == FILL;
        bus.frame_valid = state == HOLD;
        bus.fill_count  = count;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)                                          count <= '0;
        else if (bus.clear || (state == HOLD && bus.frame_ack)) count <= '0;
        else if (xfer)                                    count <= count + 1'b1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane;
        always_ff @(posedge clk or posedge rst)
            if (rst)                          lane <= '0;
            else if (xfer && count == CW'(i)) lane <= bus.in_data;
        assign bus.frame_out[i*DATA_WIDTH +: DATA_WIDTH] = lane;
    end
endmodule
